// File: rtl/hex_display_pkg.sv
// hex_display_pkg: shared FSM state type, segment constants and the overflow threshold helper.
package hex_display_pkg;
  typedef enum logic [1:0] {IDLE, CONVERT, DECODE, COMMIT} state_t;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;
  function automatic logic [63:0] pow10(input int n);
    logic [63:0] r;
    r = 64'd1;
    for (int i = 0; i < n; i++) r = r * 64'd10;
    return r;
  endfunction
endpackage

// File: rtl/hex_display_ctrl_seg7.sv
// hex_display_ctrl_seg7: BCD digit to active-low seven-segment pattern, bit 0 = segment a.
module hex_display_ctrl_seg7
  import hex_display_pkg::*;
(
  input  logic [3:0] digit,
  output logic [6:0] seg
);
  always_comb begin
    case (digit)
      4'd0:    seg = 7'b1000000;
      4'd1:    seg = 7'b1111001;
      4'd2:    seg = 7'b0100100;
      4'd3:    seg = 7'b0110000;
      4'd4:    seg = 7'b0011001;
      4'd5:    seg = 7'b0010010;
      4'd6:    seg = 7'b0000010;
      4'd7:    seg = 7'b1111000;
      4'd8:    seg = 7'b0000000;
      4'd9:    seg = 7'b0010000;
      default: seg = SEG_BLANK;
    endcase
  end
endmodule

// File: rtl/hex_display_ctrl.sv
// hex_display_ctrl: serial double-dabble binary-to-BCD with one shared seg7 decoder and atomic HEX commit.
// Define HEX_LZ_BLANK_EN to blank leading zero digits (digit 0 is always shown).
module hex_display_ctrl
  import hex_display_pkg::*;
#(
  parameter int NUM_DIGITS = 6,
  parameter int VAL_W      = 20
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [VAL_W-1:0]        val_in,
  input  logic                    val_valid,
  output logic                    val_ready,
  output logic [7*NUM_DIGITS-1:0] hex_out,
  output logic                    busy,
  output logic                    overflow
);
  localparam int BW = 4 * NUM_DIGITS;
  localparam int CW = $clog2(VAL_W);
  localparam int DW = NUM_DIGITS > 1 ? $clog2(NUM_DIGITS) : 1;
  localparam logic [63:0] LIMIT = pow10(NUM_DIGITS);

  state_t                  state;
  logic [VAL_W-1:0]        bin;
  logic [BW-1:0]           bcd, bcd_adj;
  logic [CW-1:0]           bit_cnt;
  logic [DW-1:0]           dig_idx;
  logic [3:0]              nib;
  logic [6:0]              seg, seg_sel;
  logic [7*NUM_DIGITS-1:0] stage;

  assign busy = !val_ready;
  assign nib  = bcd[4*dig_idx +: 4];

  always_comb begin
    bcd_adj = bcd;
    for (int d = 0; d < NUM_DIGITS; d++)
      bcd_adj[4*d +: 4] = bcd[4*d +: 4] >= 4'd5 ? bcd[4*d +: 4] + 4'd3 : bcd[4*d +: 4];
  end

  hex_display_ctrl_seg7 u_seg7 (.digit(nib), .seg(seg));

`ifdef HEX_LZ_BLANK_EN
  logic [NUM_DIGITS-1:0] lz;
  // A digit is a leading zero when it and every digit above it are zero.
  always_comb begin
    lz = '0;
    for (int d = 1; d < NUM_DIGITS; d++) lz[d] = (bcd >> (4*d)) == '0;
  end
  assign seg_sel = overflow ? SEG_DASH : lz[dig_idx] ? SEG_BLANK : seg;
`else
  assign seg_sel = overflow ? SEG_DASH : seg;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      bin       <= '0;
      bcd       <= '0;
      bit_cnt   <= '0;
      dig_idx   <= '0;
      stage     <= {NUM_DIGITS{SEG_BLANK}};
      hex_out   <= {NUM_DIGITS{SEG_BLANK}};
      val_ready <= 1'b1;
      overflow  <= 1'b0;
    end else begin
      case (state)
        IDLE: if (val_valid) begin
          bin       <= val_in;
          bcd       <= '0;
          overflow  <= 64'(val_in) >= LIMIT;
          bit_cnt   <= CW'(VAL_W - 1);
          val_ready <= 1'b0;
          state     <= CONVERT;
        end
        CONVERT: begin
          {bcd, bin} <= {bcd_adj, bin} << 1;
          bit_cnt    <= bit_cnt - 1'b1;
          if (bit_cnt == '0) begin
            dig_idx <= '0;
            state   <= DECODE;
          end
        end
        DECODE: begin
          stage[7*dig_idx +: 7] <= seg_sel;
          dig_idx               <= dig_idx + 1'b1;
          if (dig_idx == DW'(NUM_DIGITS - 1)) state <= COMMIT;
        end
        COMMIT: begin
          hex_out   <= stage;
          val_ready <= 1'b1;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_hex_display_ctrl.sv
// tb_hex_display_ctrl: scoreboard bench; driver queues expected displays, monitor checks each commit.
`timescale 1ns/1ps
module tb_hex_display_ctrl;
  localparam int PER  = 10;
  localparam int HALF = 5;
  localparam logic [6:0] S0 = 7'b1000000, S1 = 7'b1111001, S2 = 7'b0100100, S3 = 7'b0110000,
                         S4 = 7'b0011001, S5 = 7'b0010010, S6 = 7'b0000010, S7 = 7'b1111000,
                         S8 = 7'b0000000, S9 = 7'b0010000, BL = 7'b1111111, DA = 7'b0111111;
`ifdef HEX_LZ_BLANK_EN
  localparam logic [6:0] LZ = BL;
`else
  localparam logic [6:0] LZ = S0;
`endif

  typedef struct {
    logic [41:0] hex;
    logic        ovf;
    longint      acc;
  } exp_t;

  logic        clk = 0, reset_n = 1, val_valid = 0;
  logic [19:0] val_in = '0;
  logic        val_ready, busy, overflow;
  logic [41:0] hex_out;

  exp_t        sb_q[$];
  int          nvec = 0, miss = 0;
  bit          rst_evt = 1;
  logic        prev_ready = 1, rise;
  logic [41:0] prev_hex = {6{BL}};
  longint      last_acc = 0;

  hex_display_ctrl #(.NUM_DIGITS(6), .VAL_W(20)) dut (
    .clk(clk), .reset_n(reset_n), .val_in(val_in), .val_valid(val_valid),
    .val_ready(val_ready), .hex_out(hex_out), .busy(busy), .overflow(overflow)
  );

  always #HALF clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      miss++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic send(input logic [19:0] v, input logic [41:0] h, input logic o, input bit b2b);
    int n = 0;
    exp_t e;
    @(negedge clk);
    val_in = v;
    val_valid = 1;
    while (!val_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!val_ready) begin
      chk("accept_timeout", 64'(val_ready), 64'd1);
      val_valid = 0;
      return;
    end
    e.hex = h;
    e.ovf = o;
    e.acc = longint'($time) + HALF;
    sb_q.push_back(e);
    if (b2b) chk("accept_interval", 64'(e.acc - last_acc), 64'(28 * PER));
    last_acc = e.acc;
    @(negedge clk);
    chk("ovf_at_accept", 64'(overflow), 64'(o));
    chk("busy_after_accept", 64'(busy), 64'd1);
  endtask

  task automatic wait_idle();
    int n = 0;
    val_valid = 0;
    while ((sb_q.size() != 0 || !val_ready) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) chk("idle_timeout", 64'(sb_q.size()), 64'd0);
  endtask

  always @(negedge clk) begin
    exp_t e;
    rise = val_ready && !prev_ready;
    if (!rst_evt) begin
      if (rise) begin
        if (sb_q.size() == 0) chk("unexpected_commit", 64'd1, 64'd0);
        else begin
          e = sb_q.pop_front();
          chk("hex_out", 64'(hex_out), 64'(e.hex));
          chk("overflow", 64'(overflow), 64'(e.ovf));
          chk("latency", 64'(longint'($time) - HALF - e.acc), 64'(27 * PER));
        end
      end else if (hex_out !== prev_hex) chk("partial_update", 64'(hex_out), 64'(prev_hex));
    end
    rst_evt = 0;
    prev_ready = val_ready;
    prev_hex = hex_out;
  end

  initial begin
    #(PER * 20000);
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    #2 reset_n = 0;
    repeat (3) @(negedge clk);
    reset_n = 1;
    repeat (5) @(negedge clk);
    chk("reset_hex", 64'(hex_out), 64'({6{BL}}));
    chk("reset_ready", 64'(val_ready), 64'd1);
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_ovf", 64'(overflow), 64'd0);

    send(20'd123456, {S1, S2, S3, S4, S5, S6}, 0, 0);
    wait_idle();
    send(20'd42, {LZ, LZ, LZ, LZ, S4, S2}, 0, 0);
    wait_idle();
    send(20'd1000000, {6{DA}}, 1, 0);
    send(20'd7, {LZ, LZ, LZ, LZ, LZ, S7}, 0, 1);
    wait_idle();
    send(20'd999999, {6{S9}}, 0, 0);
    send(20'd0, {LZ, LZ, LZ, LZ, LZ, S0}, 0, 1);
    send(20'd1048575, {6{DA}}, 1, 1);
    wait_idle();
    send(20'd314159, {S3, S1, S4, S1, S5, S9}, 0, 0);
    send(20'd271828, {S2, S7, S1, S8, S2, S8}, 0, 1);
    wait_idle();

    @(negedge clk);
    val_in = 20'd555555;
    val_valid = 1;
    @(negedge clk);
    val_valid = 0;
    chk("abort_busy", 64'(busy), 64'd1);
    repeat (10) @(negedge clk);
    #2;
    rst_evt = 1;
    reset_n = 0;
    #1;
    chk("abort_hex_blank", 64'(hex_out), 64'({6{BL}}));
    chk("abort_ready", 64'(val_ready), 64'd1);
    chk("abort_ovf", 64'(overflow), 64'd0);
    @(negedge clk);
    reset_n = 1;
    send(20'd9, {LZ, LZ, LZ, LZ, LZ, S9}, 0, 0);
    wait_idle();

    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, miss);
    $finish;
  end
endmodule
